// File: rtl/afu_ctrl_pkg.sv
// Shared types and default widths for the afu_user job controller.
package afu_ctrl_pkg;

    localparam int unsigned LINE_W_DEF = 512;
    localparam int unsigned CNT_W_DEF  = 32;
    localparam int unsigned SKID_D_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/afu_skid_buf.sv
// Small circular FIFO catching afu_user read data; head word is visible combinationally.
module afu_skid_buf
    import afu_ctrl_pkg::*;
#(
    parameter int unsigned W     = LINE_W_DEF,
    parameter int unsigned DEPTH = SKID_D_DEF,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Payload storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/afu_job_ctrl.sv
// Job sequencer: feeds exactly ctx_length lines into afu_user and drains as many to the sink.
module afu_job_ctrl
    import afu_ctrl_pkg::*;
#(
    parameter int unsigned LINE_W = LINE_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned SKID_D = SKID_D_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  job_length,
    output logic              busy,
    output logic              done,
    input  logic [LINE_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic [LINE_W-1:0] afu_in_din,
    output logic              afu_in_we,
    input  logic              afu_in_almost_full,
    input  logic [LINE_W-1:0] afu_out_dout,
    output logic              afu_out_re,
    input  logic              afu_out_empty,
    output logic [CNT_W-1:0]  ctx_length,
    output logic [LINE_W-1:0] snk_data,
    output logic              snk_valid,
    input  logic              snk_ready,
    output logic [CNT_W-1:0]  lines_in,
    output logic [CNT_W-1:0]  lines_out
);

    localparam int unsigned SKID_CW = $clog2(SKID_D + 1);

    state_t               state;
    logic [CNT_W-1:0]     rd_req;
    logic                 pend;
    logic [SKID_CW-1:0]   skid_count;
    logic                 skid_empty;
    logic [LINE_W-1:0]    skid_dout;
    logic                 snk_pop;
    logic                 reading;

    // Input side writes straight through while lines remain and afu_user has room.
    assign src_ready  = (state == RUN) & (lines_in < ctx_length) & ~afu_in_almost_full;
    assign afu_in_we  = src_valid & src_ready;
    assign afu_in_din = src_data;

    // A read is only issued if the skid has a slot for it even with one read still in flight.
    assign reading    = (state == RUN) | (state == FLUSH);
    assign afu_out_re = reading & ~afu_out_empty & (rd_req < ctx_length)
                      & ((CNT_W'(skid_count) + CNT_W'(pend)) < CNT_W'(SKID_D));

    assign snk_valid  = ~skid_empty;
    assign snk_data   = skid_dout;
    assign snk_pop    = snk_valid & snk_ready;

    afu_skid_buf #(
        .W     (LINE_W),
        .DEPTH (SKID_D)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (pend),
        .din   (afu_out_dout),
        .pop   (snk_pop),
        .dout  (skid_dout),
        .count (skid_count),
        .empty (skid_empty)
    );

    // Job FSM with registered status outputs and line counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            ctx_length <= '0;
            lines_in   <= '0;
            lines_out  <= '0;
            rd_req     <= '0;
            pend       <= 1'b0;
        end else begin
            done <= 1'b0;
            pend <= afu_out_re;
            if (afu_in_we) begin
                lines_in <= lines_in + CNT_W'(1);
            end
            if (snk_pop) begin
                lines_out <= lines_out + CNT_W'(1);
            end
            if (afu_out_re) begin
                rd_req <= rd_req + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        ctx_length <= job_length;
                        lines_in   <= '0;
                        lines_out  <= '0;
                        rd_req     <= '0;
                        if (job_length != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (lines_in == ctx_length) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if ((lines_out == ctx_length) && skid_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
